// File: rtl/pkg_system_mdr.sv
// Shared definitions for the MDR datapath: operation codes.
package pkg_system_mdr;

   // Operation codes; 2'b11 is left unassigned and treated as invalid.
   typedef enum logic [1:0] {
      MULT = 2'd0,
      DIV  = 2'd1,
      ROOT = 2'd2
   } op;

endpackage

// File: rtl/mdr_result_queue.sv
// Result stage for the MDR datapath. It tracks one outstanding operation,
// captures the result from the unit that matches the latched operation, and
// queues it in a show-ahead FIFO with a valid/ready handshake.
module mdr_result_queue
   import pkg_system_mdr::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_start,
   input  logic [1:0]                 i_op,
   output logic                       o_busy,
   input  logic                       i_mult_done,
   input  logic [2*DW-1:0]            i_mult_Y,
   input  logic                       i_a2_done,
   input  logic [DW-1:0]              i_a2_Y,
   input  logic [DW-1:0]              i_a2_R,
   input  logic                       i_a2_err,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [2*DW-1:0]            o_data,
   output logic [DW-1:0]              o_rem,
   output logic [1:0]                 o_op,
   output logic                       o_err,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, WAIT} state_e;

   state_e          state_q, state_d;
   op               op_q, op_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   // Entry storage; contents need no reset because the count gates visibility.
   logic [2*DW-1:0] mem_data [DEPTH];
   logic [DW-1:0]   mem_rem  [DEPTH];
   logic [1:0]      mem_op   [DEPTH];
   logic            mem_err  [DEPTH];

   logic            busy;
   logic            valid;
   logic            pop;
   logic            op_ok;
   logic            push;
   logic [2*DW-1:0] push_data;
   logic [DW-1:0]   push_rem;
   logic [1:0]      push_op;
   logic            push_err;

   assign busy  = (state_q == WAIT) || (count_q == FULL);
   assign valid = (count_q != '0);
   assign pop   = valid && i_ready;
   assign op_ok = (i_op == MULT) || (i_op == DIV) || (i_op == ROOT);

   // Next-state logic: accept starts, pick the matching done strobe, build the push entry.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      push      = 1'b0;
      push_data = '0;
      push_rem  = '0;
      push_op   = op_q;
      push_err  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start && !busy) begin
               if (op_ok) begin
                  op_d    = op'(i_op);
                  state_d = WAIT;
               end else begin
                  // Invalid code: report it immediately as an error entry.
                  push     = 1'b1;
                  push_op  = i_op;
                  push_err = 1'b1;
               end
            end
         end
         WAIT: begin
            case (op_q)
               MULT: begin
                  if (i_mult_done) begin
                     push      = 1'b1;
                     push_data = i_mult_Y;
                  end
               end
               DIV: begin
                  if (i_a2_done) begin
                     push      = 1'b1;
                     push_data = {{DW{1'b0}}, i_a2_Y};
                     push_rem  = i_a2_R;
                     push_err  = i_a2_err;
                  end
               end
               ROOT: begin
                  // The divide-by-zero flag has no meaning for a root.
                  if (i_a2_done) begin
                     push      = 1'b1;
                     push_data = {{DW{1'b0}}, i_a2_Y};
                     push_rem  = i_a2_R;
                  end
               end
               default: state_d = IDLE;
            endcase
            if (push) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointer and occupancy update; push never meets a full FIFO.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= MULT;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage write port.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr_q] <= push_data;
         mem_rem[wr_ptr_q]  <= push_rem;
         mem_op[wr_ptr_q]   <= push_op;
         mem_err[wr_ptr_q]  <= push_err;
      end
   end

   assign o_busy  = busy;
   assign o_valid = valid;
   assign o_count = count_q;
   assign o_data  = valid ? mem_data[rd_ptr_q] : '0;
   assign o_rem   = valid ? mem_rem[rd_ptr_q]  : '0;
   assign o_op    = valid ? mem_op[rd_ptr_q]   : '0;
   assign o_err   = valid ? mem_err[rd_ptr_q]  : 1'b0;

endmodule
